// File: rtl/pipemem_ctrl.sv
// pipemem_ctrl: MEM-stage sequencer that turns loads/stores into a req/ack memory
// transaction, freezes the pipeline while outstanding, aborts on bus timeout and counts stalls.
module pipemem_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             mvalid,
  input  logic             mwmem,
  input  logic             mm2reg,
  input  logic [31:0]      malu,
  input  logic [31:0]      mb,
  input  logic             mem_ack,
  input  logic [31:0]      mem_rdata,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             stall,
  output logic             mdone,
  output logic [31:0]      mmo,
  output logic             bus_err,
  output logic             err_flag,
  output logic [CNT_W-1:0] stall_cnt
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t state, state_next;
  logic [7:0] tcnt;
  logic access, timed_out;
  assign access = mvalid & (mwmem | mm2reg);
  // ack takes priority over an expiring timeout in the same cycle
  assign timed_out = ~mem_ack & (tcnt == 8'(TIMEOUT - 1));
  always_comb begin
    state_next = state;
    stall = 1'b0;
    mdone = 1'b0;
    state_next = state == IDLE ? (access ? REQ : IDLE) :
                 state == REQ  ? ((mem_ack | timed_out) ? DONE : REQ) : IDLE;
    stall = (state == IDLE && access) || state == REQ;
    mdone = state == DONE;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_next;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mmo       <= '0;
      bus_err   <= 1'b0;
      err_flag  <= 1'b0;
      stall_cnt <= '0;
      tcnt      <= '0;
    end else begin
      bus_err <= 1'b0;
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (state == IDLE && access) begin
        mem_addr  <= malu;
        mem_wdata <= mb;
        mem_we    <= mwmem;
        mem_req   <= 1'b1;
        tcnt      <= '0;
      end
      if (state == REQ) begin
        if (mem_ack) begin
          if (!mem_we) mmo <= mem_rdata;
          mem_req <= 1'b0;
        end else if (timed_out) begin
          mmo      <= '0;
          mem_req  <= 1'b0;
          bus_err  <= 1'b1;
          err_flag <= 1'b1;
        end else tcnt <= tcnt + 8'd1;
      end
    end
endmodule

// File: tb/tb_pipemem_ctrl.sv
// tb_pipemem_ctrl: directed scenarios for pipemem_ctrl; completion results are
// checked from a scoreboard queue by a monitor that watches mdone.
module tb_pipemem_ctrl;
  localparam int TIMEOUT = 4;
  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  logic clock = 1'b0, reset = 1'b1;
  logic mvalid = 0, mwmem = 0, mm2reg = 0, mem_ack = 0;
  logic [31:0] malu = 0, mb = 0, mem_rdata = 0;
  logic mem_req, mem_we, stall, mdone, bus_err, err_flag;
  logic [31:0] mem_addr, mem_wdata, mmo;
  logic [CNT_W-1:0] stall_cnt;
  int checks = 0, failures = 0;
  int rises = 0, issues = 0, model_cnt = 0;
  logic [31:0] model_mmo = 0;
  logic model_err = 0;
  logic prev_req = 0;
  logic [32:0] sb_q[$];

  pipemem_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .mvalid(mvalid), .mwmem(mwmem), .mm2reg(mm2reg),
    .malu(malu), .mb(mb), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .stall(stall), .mdone(mdone), .mmo(mmo), .bus_err(bus_err), .err_flag(err_flag),
    .stall_cnt(stall_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: every completion must match the oldest expected result
  initial forever begin
    @(negedge clock);
    if (mem_req && !prev_req) rises++;
    prev_req = mem_req;
    if (mdone) begin
      if (sb_q.size() == 0) chk("mdone_unexpected", 1, 0);
      else begin
        logic [32:0] e;
        e = sb_q.pop_front();
        chk("sb_mmo", mmo, e[31:0]);
        chk("sb_bus_err", {31'b0, bus_err}, {31'b0, e[32]});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ack_at < 1 means no ack: the access must time out
  task automatic run_access(input logic w, input logic l, input logic [31:0] a,
                            input logic [31:0] d, input int ack_at, input logic [31:0] rd);
    logic to;
    int last;
    logic [31:0] exp;
    to = ack_at < 1 || ack_at > TIMEOUT;
    last = to ? TIMEOUT : ack_at;
    exp = to ? 32'h0 : (w ? model_mmo : rd);
    model_mmo = exp;
    model_err = model_err | to;
    issues++;
    sb_q.push_back({to, exp});
    mvalid = 1; mwmem = w; mm2reg = l; malu = a; mb = d;
    for (int c = 0; c <= last + 1; c++) begin
      mem_ack = (c == ack_at);
      mem_rdata = (c == ack_at) ? rd : 32'hBAD0_0000 + c;
      @(negedge clock);
      chk("stall", {31'b0, stall}, {31'b0, c <= last});
      chk("mem_req", {31'b0, mem_req}, {31'b0, c >= 1 && c <= last});
      chk("mdone", {31'b0, mdone}, {31'b0, c == last + 1});
      if (c <= last) chk("bus_err_quiet", {31'b0, bus_err}, 0);
      if (c == 1) begin
        chk("mem_we", {31'b0, mem_we}, {31'b0, w});
        chk("mem_addr", mem_addr, a);
        chk("mem_wdata", mem_wdata, d);
      end
      tick();
    end
    mvalid = 0; mwmem = 0; mm2reg = 0; mem_ack = 0;
    model_cnt = (model_cnt + last + 1 > CNT_MAX) ? CNT_MAX : model_cnt + last + 1;
    chk("stall_cnt", {28'b0, stall_cnt}, model_cnt);
    chk("err_flag", {31'b0, err_flag}, {31'b0, model_err});
  endtask

  initial begin
    tick();
    tick();
    @(negedge clock);
    chk("rst_req", {31'b0, mem_req}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_mmo", mmo, 0);
    chk("rst_cnt", {28'b0, stall_cnt}, 0);
    chk("rst_err", {30'b0, err_flag, bus_err}, 0);
    tick();
    reset = 0;
    run_access(0, 1, 32'h100, 32'h0, 3, 32'hDEADBEEF);
    run_access(1, 0, 32'h20, 32'h12345678, 1, 32'h55555555);
    run_access(1, 1, 32'h24, 32'hA5A5A5A5, 2, 32'h66666666);
    run_access(0, 1, 32'h40, 32'h0, -1, 32'h0);
    run_access(0, 1, 32'h44, 32'h0, TIMEOUT, 32'h0BADF00D);
    run_access(0, 1, 32'h48, 32'h0, 1, 32'h11111111);
    run_access(0, 1, 32'h4C, 32'h0, 1, 32'h22222222);
    mvalid = 1; mwmem = 0; mm2reg = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      chk("nonmem_stall", {31'b0, stall}, 0);
      chk("nonmem_req", {31'b0, mem_req}, 0);
      tick();
    end
    mvalid = 0; mwmem = 1; mm2reg = 1;
    @(negedge clock);
    chk("bubble_stall", {31'b0, stall}, 0);
    tick();
    run_access(0, 1, 32'h50, 32'h0, 1, 32'h33333333);
    chk("sat_cnt", {28'b0, stall_cnt}, CNT_MAX);
    mvalid = 1; mm2reg = 1; mwmem = 0; malu = 32'h300;
    issues++;
    tick();
    @(negedge clock);
    chk("pre_rst_req", {31'b0, mem_req}, 1);
    tick();
    #2;
    reset = 1; mvalid = 0; mm2reg = 0;
    #1;
    chk("async_req", {31'b0, mem_req}, 0);
    chk("async_addr", mem_addr, 0);
    chk("async_mmo", mmo, 0);
    chk("async_cnt", {28'b0, stall_cnt}, 0);
    chk("async_err", {31'b0, err_flag}, 0);
    chk("async_stall", {30'b0, stall, mdone}, 0);
    model_mmo = 0; model_err = 0; model_cnt = 0;
    tick();
    reset = 0; mem_ack = 1; mem_rdata = 32'hFFFFFFFF;
    @(negedge clock);
    chk("late_ack_done", {31'b0, mdone}, 0);
    tick();
    mem_ack = 0;
    @(negedge clock);
    chk("late_ack_idle", {30'b0, mdone, mem_req}, 0);
    chk("late_ack_mmo", mmo, 0);
    tick();
    run_access(0, 1, 32'h400, 32'h0, 2, 32'hCAFEF00D);
    tick();
    chk("sb_empty", sb_q.size(), 0);
    chk("req_rises", rises, issues);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipemem_ctrl.md
# pipemem_ctrl

Sequencer for the MEM stage of the five-stage pipeline. It turns load/store instructions leaving the EXE/MEM pipeline register into a req/ack transaction on a multi-cycle data memory. While the access is outstanding it freezes the pipeline from PC through EXE/MEM, then hands the load data to MEM/WB. It also enforces a bus timeout and counts stall cycles for performance monitoring.

## Interface
Parameters:
- TIMEOUT, 16: maximum cycles in REQ without ack before abort; legal range 2..255.
- CNT_W, 32: width of the stall-cycle counter.

Ports:
- clock  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- mvalid  in  1  instruction in MEM stage is valid (not a bubble).
- mwmem  in  1  store, from EXE/MEM register.
- mm2reg  in  1  load, from EXE/MEM register.
- malu  in  32  effective address, from EXE/MEM register.
- mb  in  32  store data, from EXE/MEM register.
- mem_ack  in  1  memory completion, one-cycle pulse.
- mem_rdata  in  32  read data; valid in the cycle mem_ack=1.
- mem_req  out  1  access request, registered.
- mem_we  out  1  1=write, 0=read; registered.
- mem_addr  out  32  registered address.
- mem_wdata  out  32  registered store data.
- stall  out  1  hold PC, IF/ID, ID/EXE and EXE/MEM; MEM/WB loads a bubble.
- mdone  out  1  memory access completes this cycle; MEM/WB captures mmo.
- mmo  out  32  registered load data.
- bus_err  out  1  one-cycle pulse on timeout abort.
- err_flag  out  1  sticky timeout indicator; cleared only by reset.
- stall_cnt  out  CNT_W  saturating count of stalled cycles.

## Operation
- access = mvalid & (mwmem | mm2reg). If mwmem and mm2reg are both 1, treat as a store.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - If access: stall=1. On the edge, latch mem_addr=malu, mem_wdata=mb, mem_we=mwmem, set mem_req=1, clear the timeout counter, go to REQ.
  - Otherwise: stall=0, mdone=0, remain in IDLE.
- REQ:
  - stall=1. mem_req, mem_we, mem_addr and mem_wdata hold stable.
  - On mem_ack=1: mmo<=mem_rdata for a load, mmo unchanged for a store. mem_req<=0. Go to DONE.
  - If mem_ack=0 and the counter equals TIMEOUT-1: mmo<=0, mem_req<=0, bus_err<=1 for one cycle, err_flag<=1, go to DONE.
  - Otherwise increment the counter.
  - If ack and timeout occur in the same cycle, ack wins and no error is raised.
- DONE:
  - stall=0, mdone=1. The pipeline advances on this edge.
  - Always go to IDLE. access is not re-evaluated in DONE, so the same instruction is never issued twice.
  - A memory instruction that immediately follows in EXE/MEM is evaluated in the following IDLE cycle.
- stall and mdone are combinational from state and access. All mem_* outputs, mmo, bus_err, err_flag and stall_cnt are registered.
- stall_cnt increments every cycle stall=1 and saturates at 2^CNT_W-1.
- mem_ack received outside REQ is ignored.
- Reset (asynchronous, any state, including mid-transaction):
  - state=IDLE.
  - mem_req, mem_we, mem_addr, mem_wdata, mmo = 0.
  - bus_err, err_flag, stall_cnt, timeout counter = 0.
  - An outstanding request is abandoned; a late ack is ignored.

## Timing
- Non-memory instructions: zero added latency; stall=0 throughout.
- Access detected in cycle 0 (IDLE, stall=1). mem_req=1 from cycle 1. If ack arrives in cycle k≥1, the FSM is in DONE in cycle k+1 with mdone=1 and mmo valid.
- Stall cycles per access = k+1. The minimum is 2, with ack in cycle 1.
- Timeout: mem_req is high for cycles 1..TIMEOUT. bus_err pulses in cycle TIMEOUT+1, which is the DONE cycle. The stall lasts TIMEOUT+1 cycles.
- mem_req deasserts in the DONE cycle. Back-to-back accesses therefore leave at least 2 cycles between successive mem_req rising edges.

## Test plan
- Load: mvalid=1, mm2reg=1, malu=0x100, ack in cycle 3 with rdata=0xDEADBEEF -> mem_req high in cycles 1–3, mem_we=0, mem_addr=0x100; stall high in cycles 0–3; mdone=1 and mmo=0xDEADBEEF in cycle 4; stall_cnt=4.
- Store: mwmem=1, malu=0x20, mb=0x12345678, ack in cycle 1 -> mem_we=1, mem_wdata=0x12345678; stall high in cycles 0–1; mdone in cycle 2; mmo unchanged.
- Timeout with TIMEOUT=4 and no ack -> mem_req high in cycles 1–4; bus_err pulse and mdone in cycle 5; mmo=0; err_flag stays 1 through later successful accesses.
- Ack and timeout in the same cycle (TIMEOUT=4, ack in cycle 4) -> no bus_err; mmo=rdata.
- Two consecutive loads with immediate acks -> each issued exactly once; mem_req rising edges at cycles 1 and 4; non-memory instruction between them causes no stall.
- Reset asserted in cycle 2 of a REQ -> mem_req=0 immediately and all outputs 0; ack arriving in cycle 3 is ignored; a subsequent load works normally.
